// File: rtl/serial_alu_nbit_if.sv
// serial_alu_nbit_if: request/response bundle between the register-file side
// (master) and the serial ALU (slave). WIDTH must match the ALU's WIDTH.
interface serial_alu_nbit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             binv;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             zero;
  logic             error;

  modport master (
    output start, op, a, b, binv, cin,
    input  busy, done, y, cout, zero, error
  );

  modport slave (
    input  start, op, a, b, binv, cin,
    output busy, done, y, cout, zero, error
  );
endinterface

// File: rtl/serial_alu_nbit.sv
// serial_alu_nbit: multi-cycle ALU that walks its operands BPC bits per clock,
// LSB first. AND / OR / ADD (SUB through binv+cin), with zero, carry-out and
// error flags. Results are loaded into output registers on entry to DONE and
// held until the next DONE entry.
// Optional feature: define SLT_EN to turn op=11 into signed set-less-than;
// without it op=11 is reserved and reports error after a single edge.
module serial_alu_nbit #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  serial_alu_nbit_if.slave  bus
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_RSV = 2'b11} op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] y_q;
  logic             cout_q, zero_q, error_q;

  logic             accept, rsv_req, last;
  logic [BPC-1:0]   slice;
  logic             c_chain, c_msb;
  logic [WIDTH-1:0] acc_nxt, y_fin;
  logic             ovf, cout_fin, error_fin;

  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last   = (cnt == CW'(N - 1));
`ifdef SLT_EN
  assign rsv_req = 1'b0;
`else
  assign rsv_req = (bus.op == OP_RSV);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: reserved ops skip RUN, start is only seen in IDLE/DONE.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start)           state_nxt = rsv_req ? DONE : RUN;
        else if (state == DONE)  state_nxt = IDLE;
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // One slice of the datapath: bitwise op or a BPC-bit ripple through carry_q.
  always_comb begin
    slice   = '0;
    c_chain = carry_q;
    c_msb   = carry_q;
    for (int i = 0; i < BPC; i++) begin
      case (op_q)
        OP_AND: slice[i] = a_q[i] & b_q[i];
        OP_OR:  slice[i] = a_q[i] | b_q[i];
        default: begin
          if (i == BPC - 1) c_msb = c_chain;
          slice[i] = a_q[i] ^ b_q[i] ^ c_chain;
          c_chain  = (a_q[i] & b_q[i]) | (c_chain & (a_q[i] ^ b_q[i]));
        end
      endcase
    end
  end

  // Final result and flags, meaningful on the last RUN edge only.
  always_comb begin
    acc_nxt   = (acc >> BPC) | (WIDTH'(slice) << (WIDTH - BPC));
    ovf       = c_msb ^ c_chain;
    y_fin     = acc_nxt;
    cout_fin  = 1'b0;
    error_fin = 1'b0;
    if (op_q == OP_ADD) begin
      cout_fin  = c_chain;
      error_fin = ovf;
    end
`ifdef SLT_EN
    if (op_q == OP_RSV) begin
      y_fin    = {{(WIDTH-1){1'b0}}, acc_nxt[WIDTH-1] ^ ovf};
      cout_fin = c_chain;
    end
`endif
  end

  // Operand latch, slice shifting and result registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the operand shift registers are reset as well; they are few
    // flops, not a memory array, and a clean reset state keeps them defined.
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      op_q    <= OP_AND;
      y_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b ^ {WIDTH{bus.binv}};
      carry_q <= bus.cin;
      op_q    <= op_t'(bus.op);
      cnt     <= '0;
      acc     <= '0;
`ifdef SLT_EN
      if (bus.op == OP_RSV) begin
        b_q     <= ~bus.b;
        carry_q <= 1'b1;
      end
`endif
      if (rsv_req) begin
        y_q     <= '0;
        cout_q  <= 1'b0;
        zero_q  <= 1'b0;
        error_q <= 1'b1;
      end
    end else if (state == RUN) begin
      a_q     <= a_q >> BPC;
      b_q     <= b_q >> BPC;
      carry_q <= c_chain;
      acc     <= acc_nxt;
      cnt     <= cnt + CW'(1);
      if (last) begin
        y_q     <= y_fin;
        cout_q  <= cout_fin;
        zero_q  <= (y_fin == '0);
        error_q <= error_fin;
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.y     = y_q;
  assign bus.cout  = cout_q;
  assign bus.zero  = zero_q;
  assign bus.error = error_q;

endmodule

// File: doc/serial_alu_nbit.md
Name: serial_alu_nbit

Overview:
Parametrised multi-cycle ALU, the WIDTH-bit successor of the single-bit adder ALU. It processes operands BPC bits per clock, LSB first, with an explicit start/busy/done handshake. Ops are AND, OR and ADD/SUB (via binv/cin), and it produces zero, carry-out and error (overflow or reserved-op) flags. It sits between the datapath register file and the result bus.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2.
BPC, 1, bits processed per clock; must divide WIDTH. N = WIDTH/BPC is the number of RUN cycles.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request; sampled only in IDLE or DONE
op  input  2  00 AND, 01 OR, 10 ADD, 11 reserved (SLT with SLT_EN)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
binv  input  1  invert B before the op
cin  input  1  carry-in for ADD (binv=1, cin=1 gives a-b)
busy  output  1  operation in progress
done  output  1  one-cycle pulse: results valid
y  output  WIDTH  result
cout  output  1  carry out of MSB (ADD/SLT only, else 0)
zero  output  1  y == 0 (forced 0 when error from reserved op)
error  output  1  signed overflow (ADD) or reserved op

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, y=0, cout=0, zero=0, error=0; shift registers and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge E0:
  - Latch a, b^{WIDTH{binv}}, cin and op.
  - Carry register = cin.
  - Counter = 0; state -> RUN; busy=1.
  - Reserved op: go straight to DONE instead.
- RUN: each edge processes BPC bits [k*BPC +: BPC].
  - AND/OR: bitwise.
  - ADD: ripple through BPC bits with the carry register.
  - After edge E_N (last slice), state -> DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - y, cout, zero, error updated on entry to DONE and held until the next DONE entry.
  - No start: next state IDLE.
  - start=1: accepted back-to-back (E0 of a new op).
- Latency: done high in the cycle after edge E_N; reserved op gives done after E1.
- Flags:
  - ADD: error = carry into MSB XOR carry out of MSB; cout = final carry.
  - AND/OR: cout=0, error=0.
  - Reserved op (no SLT_EN): y=0, cout=0, zero=0, error=1.
- start while in RUN: ignored; latched operands are unaffected by input changes during RUN.
- done and busy are never both 1.
- Reset mid-RUN: aborts immediately; no done pulse; all outputs return to reset values.
- Wrap-around: ADD is modulo 2^WIDTH; the carry lives in cout only.

Optional Feature:
SLT_EN:
- Defined: op=11 is signed set-less-than.
  - Computes a + ~b + 1 internally; binv and cin inputs are ignored.
  - Latency N, same as ADD.
  - y = {WIDTH-1 zeros, sign XOR overflow}; cout = final carry; error=0.
  - zero = (y==0).
- Undefined: op=11 is reserved, handled as the error case above.

Test Plan:
1. WIDTH=8, BPC=1: AND a=0xF0, b=0x3C, start at E0 -> done high in the cycle after E8; y=0x30, zero=0, cout=0, error=0; busy high for 8 cycles.
2. ADD a=0x7F, b=0x01, binv=0, cin=0 -> y=0x80, cout=0, error=1 (overflow), zero=0.
3. SUB a=0x05, b=0x05, binv=1, cin=1 -> y=0x00, zero=1, cout=1, error=0. Follow immediately with start during DONE, OR a=0x0F, b=0xF0 -> back-to-back done 8 cycles later, y=0xFF.
4. op=11 without SLT_EN -> done after E1, y=0x00, error=1, zero=0. With SLT_EN, a=0xFE, b=0x01 -> y=0x01 after 8 cycles; a=0x01, b=0xFE -> y=0x00, zero=1.
5. Start ADD, pulse start again at E3 with new operands -> ignored, first result returned. Then start another op and drive reset=0 after E4 -> busy=0 and y=0 immediately, no done pulse; first op after release completes normally.
6. WIDTH=8, BPC=4: ADD a=0xFF, b=0x01, cin=0 -> done in the cycle after E2; y=0x00, cout=1, zero=1, error=0.
